// File: rtl/bch_syndrome_serial.sv
// Bit-serial BCH syndrome generator over GF(2^M): evaluates S_j = c(alpha^j), j = 1..2T,
// by Horner's rule as codeword bits arrive MSB-first, then presents all 2T syndromes on a valid/ready port.
module bch_syndrome_serial #(
  parameter int         M         = 4,
  parameter int         N         = 15,
  parameter int         T         = 2,
  parameter logic [M:0] PRIM_POLY = 5'b10011
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_bit,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [2*T*M-1:0] syn,
  output logic             syn_valid,
  input  logic             syn_ready,
  output logic             err_det
);

  localparam int NSYN = 2 * T;
  localparam int Q    = (1 << M) - 1;
  localparam int CW   = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    S_COLLECT,
    S_DONE
  } state_t;

  if (N > Q) begin : g_err_n_high
    $error("bch_syndrome_serial: N must not exceed 2^M-1");
  end
  if (N < 3) begin : g_err_n_low
    $error("bch_syndrome_serial: N must be at least 3");
  end
  if (T < 1) begin : g_err_t
    $error("bch_syndrome_serial: T must be at least 1");
  end
  if (PRIM_POLY[M] != 1'b1) begin : g_err_poly
    $error("bch_syndrome_serial: PRIM_POLY must have its x^M term set");
  end

  // Multiply a field element by alpha (x), reducing modulo the primitive polynomial.
  function automatic logic [M-1:0] gf_mul_x(input logic [M-1:0] a);
    logic [M:0] s;
    s = {a, 1'b0};
    if (s[M]) s = s ^ PRIM_POLY;
    return s[M-1:0];
  endfunction

  function automatic logic [M-1:0] alpha_pow(input int e);
    logic [M-1:0] r;
    r = M'(1);
    for (int i = 0; i < (e % Q); i++) r = gf_mul_x(r);
    return r;
  endfunction

  // With c fixed at elaboration this collapses to a small XOR network per lane.
  function automatic logic [M-1:0] gf_mul_const(input logic [M-1:0] a, input logic [M-1:0] c);
    logic [M-1:0] p;
    logic [M-1:0] b;
    p = '0;
    b = a;
    for (int i = 0; i < M; i++) begin
      if (c[i]) p = p ^ b;
      b = gf_mul_x(b);
    end
    return p;
  endfunction

  state_t          r_state;
  state_t          w_state_next;
  logic [CW-1:0]   r_cnt;
  logic [M-1:0]    r_acc     [NSYN];
  logic [M-1:0]    w_acc_mul [NSYN];
  logic            w_accept;
  logic            w_last;
  logic            w_release;

  assign w_accept  = in_valid && in_ready;
  assign w_last    = (r_cnt == CW'(N - 1));
  assign w_release = syn_valid && syn_ready;

  for (genvar j = 0; j < NSYN; j++) begin : g_lane
    localparam logic [M-1:0] ALPHA_J = alpha_pow(j + 1);
    assign w_acc_mul[j]   = gf_mul_const(r_acc[j], ALPHA_J);
    assign syn[j*M +: M]  = r_acc[j];
  end

  assign err_det = |syn;

  // NOTE: sequential state is updated with <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_COLLECT;
    else     r_state <= w_state_next;
  end

  // NOTE: next-state defaults to the current state first, so no path leaves it unassigned.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_COLLECT: if (w_accept && w_last) w_state_next = S_DONE;
      S_DONE:    if (syn_ready)          w_state_next = S_COLLECT;
      default:                           w_state_next = S_COLLECT;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_COLLECT);
    syn_valid = (r_state == S_DONE);
  end

  // NOTE: the accumulators are a handful of flops, not a RAM, so they take the reset and
  // an aborted frame cannot leak into the next syndrome.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      for (int j = 0; j < NSYN; j++) r_acc[j] <= '0;
    end else if (w_accept) begin
      r_cnt <= w_last ? '0 : r_cnt + CW'(1);
      for (int j = 0; j < NSYN; j++) r_acc[j] <= w_acc_mul[j] ^ {{(M-1){1'b0}}, in_bit};
    end else if (w_release) begin
      for (int j = 0; j < NSYN; j++) r_acc[j] <= '0;
    end
  end

endmodule

// File: tb/tb_bch_syndrome_serial.sv
// Scoreboard bench for bch_syndrome_serial: a GF(16)/T=2 and a GF(32)/T=3 instance are driven by
// directed and random codewords; a monitor pops expected syndromes whenever a result is handed over.
module tb_bch_syndrome_serial;

  typedef struct packed {
    logic [29:0] syn;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  in_bit;
  logic [1:0]  in_valid;
  logic [1:0]  syn_ready;
  logic [1:0]  in_ready;
  logic [1:0]  syn_valid;
  logic [1:0]  err_det;
  logic [15:0] w_syn0;
  logic [29:0] w_syn1;
  logic [29:0] syn_x [2];

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   last_acc_cyc [2];
  exp_t exp_q [2][$];

  logic [29:0] prev_syn [2];
  logic [1:0]  prev_valid;
  logic [1:0]  prev_hs;

  assign syn_x[0] = {14'b0, w_syn0};
  assign syn_x[1] = w_syn1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bch_syndrome_serial #(.M(4), .N(15), .T(2), .PRIM_POLY(5'b10011)) u_dut4 (
    .clk      (clk),
    .rst      (rst),
    .in_bit   (in_bit[0]),
    .in_valid (in_valid[0]),
    .in_ready (in_ready[0]),
    .syn      (w_syn0),
    .syn_valid(syn_valid[0]),
    .syn_ready(syn_ready[0]),
    .err_det  (err_det[0])
  );

  bch_syndrome_serial #(.M(5), .N(31), .T(3), .PRIM_POLY(6'b100101)) u_dut5 (
    .clk      (clk),
    .rst      (rst),
    .in_bit   (in_bit[1]),
    .in_valid (in_valid[1]),
    .in_ready (in_ready[1]),
    .syn      (w_syn1),
    .syn_valid(syn_valid[1]),
    .syn_ready(syn_ready[1]),
    .err_det  (err_det[1])
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: build the antilog table of GF(2^m) and sum alpha^(i*j) over the set bits of c.
  function automatic exp_t ref_model(input int m, input int t, input int poly,
                                     input logic [30:0] cw, input int n);
    exp_t r;
    int   q;
    int   a;
    int   s;
    int   ex [32];
    q = (1 << m) - 1;
    a = 1;
    for (int i = 0; i < q; i++) begin
      ex[i] = a;
      a = a << 1;
      if ((a & (1 << m)) != 0) a = a ^ poly;
    end
    r.syn = '0;
    for (int j = 1; j <= 2 * t; j++) begin
      s = 0;
      for (int i = 0; i < n; i++) if (cw[i]) s = s ^ ex[(i * j) % q];
      r.syn = r.syn | (30'(s) << ((j - 1) * m));
    end
    r.err = (r.syn != '0);
    return r;
  endfunction

  function automatic exp_t model_k(input int k, input logic [30:0] cw);
    if (k == 0) return ref_model(4, 2, 'h13, cw, 15);
    else        return ref_model(5, 3, 'h25, cw, 31);
  endfunction

  task automatic push(input int k, input logic [29:0] s, input logic e);
    exp_t x;
    x.syn = s;
    x.err = e;
    exp_q[k].push_back(x);
  endtask

  // Feed c[n-1] first; stops after stop_after accepted bits. Returns just after a rising edge.
  task automatic send(input int k, input logic [30:0] cw, input int n, input bit gaps,
                      input int stop_after);
    int i;
    int acc;
    int budget;
    bit take;
    i = n - 1;
    acc = 0;
    budget = 0;
    while (acc < stop_after) begin
      @(negedge clk);
      in_valid[k] = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_bit[k]   = in_valid[k] ? cw[i] : 1'($urandom_range(0, 1));
      take = in_valid[k] && in_ready[k];
      if (take && (acc + 1 == n)) last_acc_cyc[k] = cyc;
      @(posedge clk);
      if (take) begin
        i--;
        acc++;
      end
      budget++;
      if (budget > 4 * n + 50) begin
        n_checks++;
        n_errors++;
        $display("FAIL send_timeout lane %0d: accepted %0d bits, required %0d", k, acc, stop_after);
        break;
      end
    end
    #1;
    in_valid[k] = 1'b0;
  endtask

  task automatic drain(input int k);
    int b;
    b = 0;
    while (exp_q[k].size() != 0 && b < 300) begin
      @(negedge clk);
      b++;
    end
    if (exp_q[k].size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain_timeout lane %0d: %0d results outstanding, required 0", k, exp_q[k].size());
      exp_q[k].delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input int k);
    check("rst_in_ready",  64'(in_ready[k]),  64'd1);
    check("rst_syn_valid", 64'(syn_valid[k]), 64'd0);
    check("rst_err_det",   64'(err_det[k]),   64'd0);
    check("rst_syn",       64'(syn_x[k]),     64'd0);
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        prev_valid[k] = 1'b0;
        prev_hs[k]    = 1'b0;
      end else begin
        check("in_ready_vs_syn_valid", 64'(in_ready[k]), 64'(!syn_valid[k]));
        if (prev_hs[k]) check("in_ready_after_handshake", 64'(in_ready[k]), 64'd1);
        if (syn_valid[k] && !prev_valid[k])
          check("syn_valid_latency", 64'(cyc), 64'(last_acc_cyc[k] + 1));
        if (syn_valid[k] && prev_valid[k])
          check("syn_stable_in_stall", 64'(syn_x[k]), 64'(prev_syn[k]));
        if (syn_valid[k] && syn_ready[k]) begin
          if (exp_q[k].size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_result lane %0d: got syn %0h, expected no output", k, syn_x[k]);
          end else begin
            exp_t e;
            e = exp_q[k].pop_front();
            check(k == 0 ? "syn_m4" : "syn_m5", 64'(syn_x[k]), 64'(e.syn));
            check(k == 0 ? "err_det_m4" : "err_det_m5", 64'(err_det[k]), 64'(e.err));
          end
        end
        prev_hs[k]    = syn_valid[k] && syn_ready[k];
        prev_valid[k] = syn_valid[k];
        prev_syn[k]   = syn_x[k];
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t m;
    logic [30:0] cw;
    int k;

    last_acc_cyc[0] = -100;
    last_acc_cyc[1] = -100;
    rst       = 1'b1;
    in_valid  = 2'b00;
    in_bit    = 2'b00;
    syn_ready = 2'b11;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_state(0);
    check_reset_state(1);
    @(posedge clk);
    #1;

    // All-zero codeword, continuous valid.
    push(0, 30'h0, 1'b0);
    send(0, 31'h0000, 15, 1'b0, 15);
    drain(0);

    // Single error at c[3].
    push(0, 30'hFAC8, 1'b1);
    send(0, 31'h0008, 15, 1'b0, 15);
    drain(0);

    // Generator polynomial of BCH(15,7) is itself a codeword.
    push(0, 30'h0, 1'b0);
    send(0, 31'h01D1, 15, 1'b0, 15);
    drain(0);

    // Double error with input bubbles and a 10-cycle consumer stall; bits offered meanwhile must be ignored.
    syn_ready[0] = 1'b0;
    push(0, 30'h2953, 1'b1);
    send(0, 31'h0003, 15, 1'b1, 15);
    repeat (10) begin
      @(negedge clk);
      in_valid[0] = 1'($urandom_range(0, 1));
      in_bit[0]   = 1'($urandom_range(0, 1));
    end
    @(posedge clk);
    #1;
    in_valid[0]  = 1'b0;
    syn_ready[0] = 1'b1;
    drain(0);

    // Back-to-back codewords with the consumer always ready.
    push(0, 30'h1111, 1'b1);
    push(0, 30'hFAC8, 1'b1);
    send(0, 31'h0001, 15, 1'b0, 15);
    send(0, 31'h0008, 15, 1'b0, 15);
    drain(0);

    // Abort a frame after 7 bits with reset, then send a fresh codeword.
    send(0, 31'(($urandom() & 32'h7FFF) | 32'h4000), 15, 1'b0, 7);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_state(0);
    push(0, 30'hFAC8, 1'b1);
    send(0, 31'h0008, 15, 1'b0, 15);
    drain(0);

    // GF(32), T=3: zero word, single error, BCH(31,16) generator.
    m = model_k(1, 31'h0);
    push(1, m.syn, m.err);
    send(1, 31'h0, 31, 1'b0, 31);
    drain(1);
    m = model_k(1, 31'h8);
    push(1, m.syn, m.err);
    send(1, 31'h8, 31, 1'b0, 31);
    drain(1);
    m = model_k(1, 31'h8FAF);
    push(1, m.syn, m.err);
    send(1, 31'h8FAF, 31, 1'b0, 31);
    drain(1);

    // Random codewords on both instances with random bubbles.
    for (int r = 0; r < 12; r++) begin
      k  = r % 2;
      cw = 31'($urandom());
      if (k == 0) cw = cw & 31'h7FFF;
      m = model_k(k, cw);
      push(k, m.syn, m.err);
      send(k, cw, (k == 0) ? 15 : 31, 1'($urandom_range(0, 1)), (k == 0) ? 15 : 31);
      drain(k);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bch_syndrome_serial.md
Name: bch_syndrome_serial

Overview:
Bit-serial, parametrised BCH syndrome generator over GF(2^M). It accepts one codeword bit per handshake, highest-order coefficient first, and evaluates S_j = c(alpha^j) for j = 1..2T by Horner's rule in parallel accumulators. After N bits it presents all 2T syndromes and an error flag on a valid/ready output port. It sits between the bit-stream deframer and the Berlekamp-Massey/Chien decoder stages, and handles any code length and error-correction capability.

Parameters:
M, 4, field degree; syndrome symbol width in bits.
N, 15, codeword length in bits; legal range 3..2^M-1.
T, 2, error-correction capability; the block computes 2T syndromes.
PRIM_POLY, 5'b10011, primitive polynomial of width M+1 with MSB=1 (default x^4+x+1).

Ports:
clk  in  1  rising-edge clock.
rst  in  1  synchronous, active-high reset.
in_bit  in  1  codeword coefficient; the first accepted bit is c[N-1], the last is c[0].
in_valid  in  1  in_bit is valid.
in_ready  out  1  block accepts in_bit this cycle.
syn  out  2T*M  packed syndromes; S_j at syn[(j-1)*M +: M].
syn_valid  out  1  syn and err_det are valid.
syn_ready  in  1  consumer accepts syn.
err_det  out  1  high when any S_j != 0.

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset values: state=COLLECT, bit counter=0, all accumulators=0, syn_valid=0, err_det=0, in_ready=1.
- Two-state FSM:
  - COLLECT: in_ready=1, syn_valid=0.
  - DONE: in_ready=0, syn_valid=1.
- Accept condition: in_valid && in_ready. On each accept, for every j in 1..2T, acc_j <= gf_mul_const(acc_j, alpha^j) ^ {{(M-1){1'b0}}, in_bit}.
- gf_mul_const is combinational multiply-by-constant reduced modulo PRIM_POLY. Constants alpha^j are derived at elaboration from PRIM_POLY. Exponents wrap mod 2^M-1. No lookup ROM port.
- Bit counter:
  - Width $clog2(N).
  - Increments on each accept.
  - On the accept where counter==N-1: counter <= 0, state <= DONE.
- Latency: syn_valid rises the cycle after the Nth accepted bit.
- In DONE:
  - syn = accumulators; err_det = OR-reduce of all accumulators.
  - Both are held stable until syn_ready=1.
  - in_valid is ignored and no bit is consumed.
- Exit from DONE on syn_valid && syn_ready: all accumulators <= 0, state <= COLLECT, so in_ready=1 on the next cycle. No combinational path exists from syn_ready to in_ready. Minimum inter-codeword gap is therefore 1 cycle.
- in_valid gaps: the counter and accumulators hold their values. Arbitrary bubbles are legal.
- Reset mid-codeword or in DONE: partial state is discarded; the next accepted bit is treated as c[N-1].
- err_det is not valid and not checked while syn_valid=0. It is driven from the accumulators and reads 0 after reset.
- Elaboration errors ($error): N > 2^M-1, N < 3, T < 1, PRIM_POLY[M] != 1.
- Fully synchronous; no latches; all outputs registered or decoded directly from registered state.

Test Plan:
Defaults M=4, N=15, T=2, with x^4+x+1. Codewords are shown as 15-bit hex, c[14] sent first.

1. All-zero codeword 0x0000, in_valid held high -> syn_valid rises at cycle 16 after the first accept; S1..S4=0; err_det=0; in_ready=0 until syn_ready.
2. Single error at c[3] (0x0008) -> S1=4'b1000, S2=4'b1100, S3=4'b1010, S4=4'b1111; err_det=1.
3. Valid BCH(15,7) codeword equal to generator g(x)=x^8+x^7+x^6+x^4+1 (0x01D1) -> all syndromes 0; err_det=0.
4. Double error c[0],c[1] (0x0003), with in_valid toggled randomly and syn_ready held low 10 cycles:
   - S1=0011, S2=0101, S3=1001, S4=0010.
   - syn stable throughout the stall.
   - in_ready stays 0 and no bits are consumed during the stall.
5. Back-to-back codewords 0x0001 then 0x0008, syn_ready tied high:
   - first result all syndromes 0001.
   - second result matches scenario 2.
   - exactly 1 idle cycle between them.
6. Assert rst after 7 accepted bits, then send 0x0008 -> result matches scenario 2, with no residue from the aborted frame.
7. Re-run scenarios 1-3 with M=5, N=31, T=3, PRIM_POLY=6'b100101; check against the software reference model.
